tx_axis_arbiter: RTL and testbench
==================================

TX_AXIS_ARBITER -- requirements
Module: tx_axis_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of TX AXIS requesters, legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXIS data width matching the MAC TX AXIS; KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have port i_clk, input, 1, single clock, driven from the transceiver TX user clock (s00_axis_aclk of eth_10g).
REQ-004 SHALL have port i_reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have requester ports s_axis_tdata (in, NUM_PORTS x DATA_WIDTH), s_axis_tkeep (in, NUM_PORTS x KEEP_WIDTH), s_axis_tvalid (in, NUM_PORTS), s_axis_tlast (in, NUM_PORTS) and s_axis_tready (out, NUM_PORTS), all packed, port index p occupying slice p.
REQ-006 SHALL have MAC-side ports m00_axis_tdata (out, DATA_WIDTH), m00_axis_tkeep (out, KEEP_WIDTH), m00_axis_tvalid (out, 1), m00_axis_tlast (out, 1) and m00_axis_tready (in, 1).
REQ-007 SHALL have status port o_busy, out, 1, high while a packet is granted.
REQ-008 SHALL have status port o_grant_port, out, clog2(NUM_PORTS), index of the current or last granted port.

Function
REQ-009 SHALL implement a packet-level round-robin arbiter with states IDLE and PASS.
REQ-010 In IDLE, SHALL drive m00_axis_tvalid=0 and all s_axis_tready=0.
REQ-011 In IDLE, with any s_axis_tvalid high, SHALL register the grant as the first valid port searching upward (with wrap) from last_grant+1, and enter PASS on the next edge.
REQ-012 In PASS, SHALL combinationally route granted port's tdata/tkeep/tvalid/tlast to m00, assert s_axis_tready[grant]=m00_axis_tready, and hold all other s_axis_tready at 0.
REQ-013 SHALL hold the grant unchanged for the whole packet regardless of other requesters' tvalid.
REQ-014 On handshake (m00_axis_tvalid & m00_axis_tready & m00_axis_tlast), SHALL return to IDLE on the next edge and record last_grant=grant.
REQ-015 SHALL impose exactly one IDLE cycle between packets: arbitration latency is 1 cycle from IDLE-with-request to first beat offered.
REQ-016 A granted port dropping tvalid mid-packet SHALL only stall the transfer (m00_axis_tvalid=0) while the grant is kept; the arbiter SHALL never insert or drop beats.
REQ-017 A single-beat packet (tlast on first beat) SHALL complete in one PASS cycle.
REQ-018 Requests appearing in the IDLE arbitration cycle itself SHALL be considered in that cycle's arbitration.
REQ-019 o_busy SHALL equal (state==PASS); o_grant_port SHALL equal the registered grant.

Reset
REQ-020 Asserting i_reset_n low SHALL immediately force state=IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 wins first), o_busy=0, m00_axis_tvalid=0 and all s_axis_tready=0.
REQ-021 Reset during PASS SHALL abandon the packet without generating tlast; upstream recovery is the requester's responsibility.
REQ-022 On release, arbitration SHALL begin on the first rising edge after reset is deasserted.

Configuration
REQ-023 With macro TX_ARB_STATS_EN defined, SHALL add output o_pkt_count (NUM_PORTS x 32): per-port counters, reset to 0, incremented on that port's tlast handshake, wrapping from 0xFFFFFFFF to 0.
REQ-024 Without TX_ARB_STATS_EN, the o_pkt_count port and its counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package eth_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_PASS) and the port-index width constant function.
REQ-026 The round-robin search SHALL be a combinational sub-module rr_select (inputs: request vector, last_grant; outputs: next grant index, any-request flag).

Verification
REQ-027 Port0 only, 3-beat packet, m00_axis_tready=1 -> first beat offered 1 cycle after tvalid; beats in order; o_busy high 3 cycles.
REQ-028 Ports 0 and 1 both requesting continuously with 2-beat packets -> grant sequence 0,1,0,1; one IDLE cycle between packets.
REQ-029 Port1 mid-packet with port0 raising tvalid -> grant stays 1 until port1 tlast; port0 s_axis_tready stays 0.
REQ-030 m00_axis_tready low for 5 cycles mid-packet -> tdata held stable; no beat lost or duplicated; s_axis_tready[grant]=0 for those cycles.
REQ-031 i_reset_n pulsed low mid-packet -> m00_axis_tvalid=0 asynchronously; after release, port 0 wins the next arbitration.
REQ-032 With TX_ARB_STATS_EN, counter preloaded to 0xFFFFFFFF and one packet sent -> o_pkt_count for that port reads 0.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// ---------------------------------------------------------------------------
// eth_arb_pkg
// Shared definitions for the TX AXIS packet arbiter:
//   - arb_state_e    : arbiter FSM states (ARB_IDLE, ARB_PASS)
//   - port_idx_width : width of a port index for a given number of requesters
// ---------------------------------------------------------------------------
package eth_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  // A port index is never narrower than one bit, even for tiny port counts.
  function automatic int port_idx_width(input int num_ports);
    if (num_ports <= 2) begin
      return 1;
    end
    return $clog2(num_ports);
  endfunction

endpackage

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin search. Starting one above the last granted
// port and wrapping around, returns the first port whose request is high.
// Ports:
//   i_req        : request vector, one bit per port
//   i_last_grant : index of the most recently served port
//   o_next_grant : winning port index (0 when nothing is requesting)
//   o_any_req    : high when at least one request bit is set
// ---------------------------------------------------------------------------
module rr_select
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = port_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic [IDX_W-1:0]     o_next_grant,
  output logic                 o_any_req
);

  assign o_any_req = |i_req;

  // Offsets run 1..NUM_PORTS so the last granted port is checked last,
  // which gives it the lowest priority in this round.
  always_comb begin
    logic w_found;
    int   w_idx;
    o_next_grant = '0;
    w_found      = 1'b0;
    w_idx        = 0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      w_idx = (int'(i_last_grant) + off) % NUM_PORTS;
      if (!w_found && i_req[w_idx]) begin
        o_next_grant = IDX_W'(w_idx);
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tx_axis_arbiter
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream requesters
// onto the single MAC TX AXIS input. A grant is held for a whole packet and
// there is exactly one idle (arbitration) cycle between packets.
//
// Optional feature macro: TX_ARB_STATS_EN
//   When defined, adds o_pkt_count with one 32-bit wrapping packet counter
//   per requester.
//
// Ports:
//   i_clk, i_reset_n    : TX user clock, asynchronous active-low reset
//   s_axis_t*           : requester streams, port p in slice p
//   m00_axis_t*         : merged stream towards the MAC
//   o_busy              : high while a packet is granted
//   o_grant_port        : current or most recently granted port
//   o_pkt_count         : per-port completed packet counts (stats build only)
// ---------------------------------------------------------------------------
module tx_axis_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = port_idx_width(NUM_PORTS)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m00_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m00_axis_tkeep,
  output logic                             m00_axis_tvalid,
  output logic                             m00_axis_tlast,
  input  logic                             m00_axis_tready,
  output logic                             o_busy,
  output logic [IDX_W-1:0]                 o_grant_port
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          o_pkt_count
`endif
);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;

  logic [IDX_W-1:0] w_next_grant;
  logic             w_any_req;
  logic             w_pass;
  logic             w_last_hs;

  rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .i_req        (s_axis_tvalid),
    .i_last_grant (r_last_grant),
    .o_next_grant (w_next_grant),
    .o_any_req    (w_any_req)
  );

  assign w_pass = (r_state == ARB_PASS);

  // Data path is a plain mux on the registered grant; only tvalid and
  // tready are qualified by the state, so IDLE never offers a beat.
  assign m00_axis_tdata  = s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign m00_axis_tkeep  = s_axis_tkeep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
  assign m00_axis_tlast  = s_axis_tlast[r_grant];
  assign m00_axis_tvalid = w_pass & s_axis_tvalid[r_grant];

  always_comb begin
    s_axis_tready = '0;
    if (w_pass) begin
      s_axis_tready[r_grant] = m00_axis_tready;
    end
  end

  assign w_last_hs = m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;

  // Reset leaves last_grant at the top port so the first search starts at 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_next_grant;
            r_state <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (w_last_hs) begin
            r_last_grant <= r_grant;
            r_state      <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_busy       = w_pass;
  assign o_grant_port = r_grant;

`ifdef TX_ARB_STATS_EN
  logic [31:0] r_pkt_count [NUM_PORTS];

  // Counters wrap naturally through the 32-bit add.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_pkt_count[i] <= '0;
      end
    end else if (w_last_hs) begin
      r_pkt_count[r_grant] <= r_pkt_count[r_grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign o_pkt_count[g*32 +: 32] = r_pkt_count[g];
  end
`endif

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_axis_arbiter
// Randomised requesters feed the arbiter; every generated beat is pushed
// into a per-port expected queue, and an independent monitor tracks the
// round-robin grant order and pops/compares beats as the MAC side accepts
// them.
// ---------------------------------------------------------------------------
module tb_tx_axis_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [NP*DW-1:0]  sTdata;
  logic [NP*KW-1:0]  sTkeep;
  logic [NP-1:0]     sTvalid;
  logic [NP-1:0]     sTlast;
  logic [NP-1:0]     sTready;
  logic [DW-1:0]     mTdata;
  logic [KW-1:0]     mTkeep;
  logic              mTvalid;
  logic              mTlast;
  logic              mTready;
  logic              busy;
  logic [IW-1:0]     grantPort;
`ifdef TX_ARB_STATS_EN
  logic [NP*32-1:0]  pktCount;
`endif

  int checks = 0;
  int errors = 0;

  beat_t       txQ  [NP][$];
  beat_t       expQ [NP][$];
  logic [NP-1:0] enMask    = '0;
  int          probValid = 100;
  int          probReady = 100;
  int          seqCnt [NP];
  int          pktDone [NP];
  logic [NP-1:0] pendingHs;

  tx_axis_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rstN),
    .s_axis_tdata    (sTdata),
    .s_axis_tkeep    (sTkeep),
    .s_axis_tvalid   (sTvalid),
    .s_axis_tlast    (sTlast),
    .s_axis_tready   (sTready),
    .m00_axis_tdata  (mTdata),
    .m00_axis_tkeep  (mTkeep),
    .m00_axis_tvalid (mTvalid),
    .m00_axis_tlast  (mTlast),
    .m00_axis_tready (mTready),
    .o_busy          (busy),
    .o_grant_port    (grantPort)
`ifdef TX_ARB_STATS_EN
    ,
    .o_pkt_count     (pktCount)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting port above the last served one, wrapping.
  function automatic int rrPick(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      int idx;
      idx = (last + k) % NP;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit queuesEmpty();
    for (int p = 0; p < NP; p++) begin
      if (txQ[p].size() != 0 || expQ[p].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sets the traffic mix and lets it run for a number of cycles.
  task automatic applyStimulus(input logic [NP-1:0] mask, input int pv, input int pr, input int cycles);
    enMask    = mask;
    probValid = pv;
    probReady = pr;
    repeat (cycles) @(negedge clk);
  endtask

  // Stops new packets and waits (bounded) for everything in flight to finish.
  task automatic drainAll();
    bit done;
    done      = 1'b0;
    enMask    = '0;
    probValid = 100;
    probReady = 100;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      #3;
      done = queuesEmpty() && !busy;
    end
    checkOutput("drain_done", 64'(done), 64'd1);
  endtask

  // Requester models: each port builds packets of 1..4 beats tagged with its
  // index and a sequence number, presents the head beat with random gaps and
  // pops it once accepted. Inputs change on the falling edge.
  initial begin
    sTvalid   = '0;
    sTdata    = '0;
    sTkeep    = '0;
    sTlast    = '0;
    mTready   = 1'b0;
    pendingHs = '0;
    for (int p = 0; p < NP; p++) seqCnt[p] = 0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        for (int p = 0; p < NP; p++) begin
          txQ[p].delete();
          expQ[p].delete();
        end
        pendingHs = '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (pendingHs[p]) void'(txQ[p].pop_front());
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (rstN && enMask[p] && txQ[p].size() == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = {4'(p), 12'(seqCnt[p]), 4'(b), 12'($urandom)};
            bt.keep = (b == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            bt.last = (b == len - 1);
            txQ[p].push_back(bt);
            expQ[p].push_back(bt);
          end
          seqCnt[p]++;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (txQ[p].size() != 0) begin
          sTdata[p*DW +: DW] = txQ[p][0].data;
          sTkeep[p*KW +: KW] = txQ[p][0].keep;
          sTlast[p]          = txQ[p][0].last;
          sTvalid[p]         = ($urandom_range(0, 99) < probValid);
        end else begin
          sTdata[p*DW +: DW] = '0;
          sTkeep[p*KW +: KW] = '0;
          sTlast[p]          = 1'b0;
          sTvalid[p]         = 1'b0;
        end
      end
      mTready = ($urandom_range(0, 99) < probReady);
      #1;
      pendingHs = sTvalid & sTready;
    end
  end

  // Monitor and reference model: one arbitration cycle with no beat, then the
  // chosen port owns the output until its tlast beat is accepted.
  initial begin
    bit            modelBusy;
    bit            wasBusy;
    int            modelGrant;
    int            modelLast;
    bit            prevStall;
    logic [DW-1:0] prevData;
    logic          expTv;
    logic [NP-1:0] expReady;
    beat_t         e;
    modelBusy  = 1'b0;
    modelGrant = 0;
    modelLast  = NP - 1;
    prevStall  = 1'b0;
    prevData   = '0;
    for (int p = 0; p < NP; p++) pktDone[p] = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstN) begin
        modelBusy  = 1'b0;
        modelGrant = 0;
        modelLast  = NP - 1;
        prevStall  = 1'b0;
        for (int p = 0; p < NP; p++) pktDone[p] = 0;
        continue;
      end
      wasBusy = modelBusy;
      checkOutput("busy", 64'(busy), 64'(modelBusy));
      checkOutput("grant_port", 64'(grantPort), 64'(modelGrant));
      expTv    = 1'b0;
      expReady = '0;
      if (modelBusy) begin
        expTv                = sTvalid[modelGrant];
        expReady[modelGrant] = mTready;
      end
      checkOutput("m_tvalid", 64'(mTvalid), 64'(expTv));
      checkOutput("s_tready", 64'(sTready), 64'(expReady));
      if (modelBusy && prevStall && expTv) begin
        checkOutput("stall_hold", 64'(mTdata), 64'(prevData));
      end
      if (modelBusy && expTv && mTready) begin
        if (expQ[modelGrant].size() == 0) begin
          checkOutput("beat_expected", 64'(expQ[modelGrant].size()), 64'd1);
        end else begin
          e = expQ[modelGrant].pop_front();
          checkOutput("tdata", 64'(mTdata), 64'(e.data));
          checkOutput("tkeep", 64'(mTkeep), 64'(e.keep));
          checkOutput("tlast", 64'(mTlast), 64'(e.last));
          if (e.last) begin
            modelBusy = 1'b0;
            modelLast = modelGrant;
            pktDone[modelGrant]++;
          end
        end
      end
      prevStall = modelBusy && expTv && !mTready;
      prevData  = mTdata;
      if (!wasBusy && (|sTvalid)) begin
        modelGrant = rrPick(sTvalid, modelLast);
        modelBusy  = 1'b1;
      end
    end
  end

  // Test sequence: reset state, directed-ish traffic mixes, reset mid-packet.
  initial begin
    bit seen;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_m_tvalid", 64'(mTvalid), 64'd0);
    checkOutput("reset_s_tready", 64'(sTready), 64'd0);
    checkOutput("reset_grant", 64'(grantPort), 64'd0);
    rstN = 1'b1;

    $display("[TB] port 0 alone, MAC always ready");
    applyStimulus(3'b001, 100, 100, 40);
    $display("[TB] ports 0 and 1 back to back");
    applyStimulus(3'b011, 100, 100, 60);
    $display("[TB] all ports, gaps and backpressure");
    applyStimulus(3'b111, 70, 60, 400);
    applyStimulus(3'b111, 100, 25, 300);
    drainAll();

    $display("[TB] reset in the middle of a packet");
    enMask    = 3'b111;
    probValid = 100;
    probReady = 50;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #3;
      seen = busy && mTvalid && !mTlast;
    end
    checkOutput("midpkt_reached", 64'(seen), 64'd1);
    rstN   = 1'b0;
    enMask = '0;
    #1;
    checkOutput("async_m_tvalid", 64'(mTvalid), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_s_tready", 64'(sTready), 64'd0);
    repeat (2) @(negedge clk);
    #3;
    rstN      = 1'b1;
    enMask    = 3'b101;
    probReady = 100;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #3;
      seen = busy;
    end
    checkOutput("post_reset_busy", 64'(seen), 64'd1);
    checkOutput("post_reset_grant", 64'(grantPort), 64'd0);
    applyStimulus(3'b111, 80, 80, 300);
    drainAll();

`ifdef TX_ARB_STATS_EN
    for (int p = 0; p < NP; p++) begin
      checkOutput("pkt_count", 64'(pktCount[p*32 +: 32]), 64'(pktDone[p]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
